// File: rtl/ov7670_capture.sv
// OV7670 capture stage: oversamples the camera pins in the clk_i domain,
// pairs bytes into RGB444 pixels and writes them linearly into VRAM.
// Optional framing checks are compiled in with `define CAPTURE_ERROR_CHECK_EN.
module ov7670_capture #(
  parameter int ACTIVE_COLUMNS  = 640,
  parameter int ACTIVE_ROWS     = 480,
  parameter int VRAM_DATA_WIDTH = 12,
  parameter int VRAM_ADDR_WIDTH = $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS)
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pixel_clk_cmos_i,
  input  logic                       vsync_cmos_i,
  input  logic                       href_cmos_i,
  input  logic [7:0]                 pixel_data_cmos_i,
  output logic                       vram_wr_en_o,
  output logic [VRAM_ADDR_WIDTH-1:0] vram_wr_addr_o,
  output logic [VRAM_DATA_WIDTH-1:0] vram_wr_data_o,
  output logic                       frame_done_o,
  output logic                       error_o
);

  // Pointer is one bit wider than the port so it can reach the full-frame count.
  localparam int PW = VRAM_ADDR_WIDTH + 1;
  localparam int CW = $clog2(ACTIVE_COLUMNS + 1);
  localparam int RW = $clog2(ACTIVE_ROWS + 2);
  localparam logic [PW-1:0] TOTAL_C    = PW'(ACTIVE_COLUMNS * ACTIVE_ROWS);
  localparam logic [CW-1:0] COLS_C     = CW'(ACTIVE_COLUMNS);
  localparam logic [RW-1:0] ROWS_C     = RW'(ACTIVE_ROWS);
  localparam logic [RW-1:0] ROWS_SAT_C = RW'(ACTIVE_ROWS + 1);

  typedef enum logic [1:0] {S_SYNC, S_WAIT, S_ACTIVE} state_e;

  // {pclk, vsync, href, data} travel together so data stays aligned with PCLK
  logic [10:0] sync1_q, sync2_q;
  logic        pclk_s, vsync_s, href_s;
  logic [7:0]  byte_s;
  logic        pclk_prev_q, vsync_prev_q, href_prev_q;
  logic        pclk_rise_q, vsync_rise_q, vsync_fall_q, href_fall_q;
  logic        vsync_q, href_q;
  logic [7:0]  byte_q;

  assign pclk_s  = sync2_q[10];
  assign vsync_s = sync2_q[9];
  assign href_s  = sync2_q[8];
  assign byte_s  = sync2_q[7:0];

  // Two-flop synchronizers, previous-value copies and registered edge events
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      pclk_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      pclk_rise_q  <= 1'b0;
      vsync_rise_q <= 1'b0;
      vsync_fall_q <= 1'b0;
      href_fall_q  <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      byte_q       <= '0;
    end else begin
      sync1_q      <= {pixel_clk_cmos_i, vsync_cmos_i, href_cmos_i, pixel_data_cmos_i};
      sync2_q      <= sync1_q;
      pclk_prev_q  <= pclk_s;
      vsync_prev_q <= vsync_s;
      href_prev_q  <= href_s;
      pclk_rise_q  <= pclk_s & ~pclk_prev_q;
      vsync_rise_q <= vsync_s & ~vsync_prev_q;
      vsync_fall_q <= ~vsync_s & vsync_prev_q;
      href_fall_q  <= ~href_s & href_prev_q;
      vsync_q      <= vsync_s;
      href_q       <= href_s;
      byte_q       <= byte_s;
    end
  end

  state_e                     state_q, state_d;
  logic [PW-1:0]              ptr_q, ptr_d;
  logic [CW-1:0]              col_q, col_d, col_w;
  logic [RW-1:0]              row_q, row_d, row_w;
  logic                       phase_q, phase_d, phase_w;
  logic [3:0]                 r_q, r_d;
  logic                       wr_en_q, wr_en_d;
  logic [VRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [VRAM_DATA_WIDTH-1:0] data_q, data_d;
  logic                       done_q, done_d;
  logic                       byte_go, wr_try, wr_block, wr_go;

  // Per-cycle capture decisions; *_w are counter values after this cycle's
  // write but before any line-end clear, so a write coinciding with HREF
  // fall is accounted for before the line is closed.
  assign byte_go  = (state_q == S_ACTIVE) && pclk_rise_q && href_q;
  assign wr_try   = byte_go && phase_q;
  assign wr_block = (ptr_q == TOTAL_C) || (col_q == COLS_C);
  assign wr_go    = wr_try && !wr_block;
  assign col_w    = wr_go ? col_q + 1'b1 : col_q;
  assign phase_w  = byte_go ? ~phase_q : phase_q;
  assign row_w    = (href_fall_q && row_q != ROWS_SAT_C) ? row_q + 1'b1 : row_q;

  // FSM and datapath state register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_SYNC;
      ptr_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      phase_q <= 1'b0;
      r_q     <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      col_q   <= col_d;
      row_q   <= row_d;
      phase_q <= phase_d;
      r_q     <= r_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  // Next-state: frame sync, byte pairing, line and frame boundaries
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    col_d   = col_q;
    row_d   = row_q;
    phase_d = phase_q;
    r_d     = r_q;
    wr_en_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      S_SYNC: begin
        if (vsync_q) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (vsync_fall_q) begin
          ptr_d   = '0;
          col_d   = '0;
          row_d   = '0;
          phase_d = 1'b0;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (byte_go && !phase_q) r_d = byte_q[3:0];
        if (wr_go) begin
          wr_en_d = 1'b1;
          addr_d  = ptr_q[VRAM_ADDR_WIDTH-1:0];
          data_d  = VRAM_DATA_WIDTH'({r_q, byte_q});
          ptr_d   = ptr_q + 1'b1;
        end
        col_d   = col_w;
        phase_d = phase_w;
        row_d   = row_w;
        if (href_fall_q) begin
          col_d   = '0;
          phase_d = 1'b0;
        end
        if (vsync_rise_q) begin
          done_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_SYNC;
    endcase
  end

  assign vram_wr_en_o   = wr_en_q;
  assign vram_wr_addr_o = addr_q;
  assign vram_wr_data_o = data_q;
  assign frame_done_o   = done_q;

`ifdef CAPTURE_ERROR_CHECK_EN
  logic err_q, err_set;

  // Framing violations: short/odd line, wrong row count, suppressed write
  always_comb begin
    err_set = (state_q == S_ACTIVE) &&
              ((wr_try && wr_block) ||
               (href_fall_q && (col_w != COLS_C || phase_w)) ||
               (vsync_rise_q && row_w != ROWS_C));
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (reset_i) err_q <= 1'b0;
    else         err_q <= err_q | err_set;
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a 4x2 frame.
module tb_ov7670_capture;

  localparam int COLS = 4;
  localparam int ROWS = 2;
`ifdef CAPTURE_ERROR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pclk = 1'b0, vsync = 1'b0, href = 1'b0;
  logic [7:0]  pdata = 8'h00;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;

  ov7670_capture #(.ACTIVE_COLUMNS(COLS), .ACTIVE_ROWS(ROWS)) dut (
    .clk_i(clk), .reset_i(reset),
    .pixel_clk_cmos_i(pclk), .vsync_cmos_i(vsync), .href_cmos_i(href),
    .pixel_data_cmos_i(pdata),
    .vram_wr_en_o(wr_en), .vram_wr_addr_o(wr_addr), .vram_wr_data_o(wr_data),
    .frame_done_o(frame_done), .error_o(error)
  );

  always #5 clk = ~clk;

  // Write monitor, sampled on the falling edge
  logic [2:0]  got_addr[$];
  logic [11:0] got_data[$];
  logic [2:0]  exp_addr[$];
  logic [11:0] exp_data[$];
  int  wide_cnt = 0;
  int  done_cnt = 0;
  logic en_prev = 1'b0;
  time last_wr_time = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
      last_wr_time <= $time;
      if (en_prev) wide_cnt <= wide_cnt + 1;
    end
    if (frame_done) done_cnt <= done_cnt + 1;
    en_prev <= wr_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state for expected writes
  bit  model_on = 0;
  int  exp_ptr = 0;
  int  line_no = 0;
  time rise_time = 0;

  task automatic send_byte(input logic [7:0] b);
    pdata = b;
    #20 pclk = 1'b1;
    rise_time = $time;
    #20 pclk = 1'b0;
  endtask

  task automatic send_line(input int n);
    logic [7:0] b;
    logic [3:0] r_nib;
    int col;
    col = 0;
    r_nib = 4'h0;
    href = 1'b1;
    for (int i = 0; i < n; i++) begin
      b = 8'(i * 37 + line_no * 91 + 90);
      if (i % 2 == 0) begin
        r_nib = b[3:0];
      end else if (model_on && col < COLS && exp_ptr < COLS * ROWS) begin
        exp_addr.push_back(3'(exp_ptr));
        exp_data.push_back({r_nib, b});
        exp_ptr++;
        col++;
      end
      send_byte(b);
    end
    href = 1'b0;
    line_no++;
    #60;
  endtask

  task automatic start_frame();
    vsync = 1'b1;
    #80 vsync = 1'b0;
    #80;
    model_on = 1;
    exp_ptr = 0;
  endtask

  task automatic end_frame();
    vsync = 1'b1;
    #80;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #30 reset = 1'b0;
    #20;
    model_on = 0;
  endtask

  task automatic verify(input string tag);
    int n;
    n = exp_data.size();
    check($sformatf("%s_count", tag), got_data.size(), n);
    for (int i = 0; i < n && i < got_data.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s_data%0d", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
    end
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  int done_base;

  initial begin
    // Reset with random pin activity
    for (int i = 0; i < 3; i++) begin
      #10;
      pclk  = 1'($urandom);
      vsync = 1'($urandom);
      href  = 1'($urandom);
      pdata = 8'($urandom);
    end
    check("rst_en",   32'(wr_en), 0);
    check("rst_addr", 32'(wr_addr), 0);
    check("rst_data", 32'(wr_data), 0);
    check("rst_done", 32'(frame_done), 0);
    check("rst_err",  32'(error), 0);
    pclk = 1'b0; vsync = 1'b0; href = 1'b0; pdata = 8'h00;
    #10 reset = 1'b0;
    #40;
    check("rst_writes", got_data.size(), 0);

    // Bytes before the first VSYNC are ignored
    send_line(4);
    verify("pre_vsync");

    // Pixel assembly and latency
    start_frame();
    exp_addr.push_back(3'd0);
    exp_data.push_back(12'hABC);
    href = 1'b1;
    send_byte(8'h0A);
    send_byte(8'hBC);
    href = 1'b0;
    #60;
    check("latency", 32'(last_wr_time - rise_time), 40);
    verify("assemble");
    check("short1_err", 32'(error), 32'(EXP_ERR));
    done_base = done_cnt;
    end_frame();
    check("assemble_done", done_cnt - done_base, 1);

    // Two identical full frames
    apply_reset();
    for (int f = 0; f < 2; f++) begin
      done_base = done_cnt;
      start_frame();
      send_line(8);
      send_line(8);
      end_frame();
      verify($sformatf("full%0d", f));
      check($sformatf("full%0d_done", f), done_cnt - done_base, 1);
      check($sformatf("full%0d_err", f), 32'(error), 0);
      check($sformatf("full%0d_hold", f), 32'(wr_addr), 7);
    end

    // Short line sets the sticky error
    start_frame();
    send_line(6);
    verify("short");
    check("short_err", 32'(error), 32'(EXP_ERR));
    send_line(8);
    end_frame();
    verify("short_rest");
    start_frame();
    send_line(8);
    send_line(8);
    end_frame();
    verify("after_short");
    check("sticky_err", 32'(error), 32'(EXP_ERR));

    // Odd byte count: dangling byte discarded
    apply_reset();
    start_frame();
    send_line(7);
    verify("odd");
    check("odd_err", 32'(error), 32'(EXP_ERR));

    // Reset mid-frame, then resume at the next full frame
    apply_reset();
    start_frame();
    send_line(6);
    verify("mid_pre");
    apply_reset();
    check("mid_rst_addr", 32'(wr_addr), 0);
    done_base = done_cnt;
    send_line(8);
    end_frame();
    verify("mid_discard");
    check("mid_done", done_cnt - done_base, 0);
    start_frame();
    send_line(8);
    send_line(8);
    end_frame();
    verify("mid_resume");
    check("mid_err", 32'(error), 0);

    check("strobe_width", wide_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Capture stage between the OV7670 camera pins and the frame-buffer VRAM write port inside `ovo7670_top`. It oversamples the camera's `pixel_clk_cmos_i`, `vsync_cmos_i`, `href_cmos_i` and `pixel_data_cmos_i` in the system clock domain. It assembles byte pairs into 12-bit RGB444 pixels and writes them at linear addresses 0 to ACTIVE_COLUMNS*ACTIVE_ROWS-1. The VGA scan-out stage reads the same VRAM on its own port.

## Interface
Parameters:
- `ACTIVE_COLUMNS`, default 640: pixels per line.
- `ACTIVE_ROWS`, default 480: lines per frame.
- `VRAM_DATA_WIDTH`, default 12: pixel width. Fixed at 12 (RGB444).
- `VRAM_ADDR_WIDTH`, default $clog2(ACTIVE_COLUMNS*ACTIVE_ROWS): write address width.

Ports:
- `clk_i`, in, 1: system clock. This is the only clock. It must be at least 4× the camera pixel clock.
- `reset_i`, in, 1: synchronous, active-high reset.
- `pixel_clk_cmos_i`, in, 1: camera PCLK. Sampled as data, never used as a clock.
- `vsync_cmos_i`, in, 1: camera VSYNC. Active high between frames.
- `href_cmos_i`, in, 1: camera HREF. High during active line bytes.
- `pixel_data_cmos_i`, in, 8: camera D[7:0]. Valid at the PCLK rising edge.
- `vram_wr_en_o`, out, 1: single-cycle write strobe.
- `vram_wr_addr_o`, out, VRAM_ADDR_WIDTH: write address.
- `vram_wr_data_o`, out, 12: pixel value, {R[3:0], G[3:0], B[3:0]}.
- `frame_done_o`, out, 1: single-cycle pulse at the end of every captured frame.
- `error_o`, out, 1: sticky framing error.

## Operation
- Input sampling:
  - All four camera inputs pass through identical 2-flop synchronizers, so data stays aligned with PCLK.
  - A registered copy of the synchronized PCLK gives the edge detector: `pclk_rise` = synced & ~previous.
  - VSYNC and HREF also get registered copies, used for rise and fall detection.
- FSM states:
  - `S_SYNC` (entered at reset): wait for synchronized VSYNC to be high.
  - `S_WAIT`: on a VSYNC falling edge, clear the address, column and row counters and the byte phase, then go to `S_ACTIVE`.
  - `S_ACTIVE`: capture pixel bytes.
- Capture in `S_ACTIVE`:
  - On `pclk_rise` with HREF high:
    - Phase 0 latches byte[3:0] as R.
    - Phase 1 forms data = {R, byte}, issues a write, then increments the address and the column counter.
    - The phase toggles on every such edge.
  - On an HREF falling edge, a line ends:
    - The row counter increments.
    - The column counter and phase clear.
  - On a VSYNC rising edge, the frame ends:
    - `frame_done_o` pulses.
    - The FSM returns to `S_WAIT`.
- Bytes outside `S_ACTIVE` are ignored. This covers capture starting mid-frame.
- Overflow protection:
  - If the address reaches ACTIVE_COLUMNS*ACTIVE_ROWS, further writes are suppressed. The address does not wrap.
  - Writes whose column counter already equals ACTIVE_COLUMNS are also suppressed.
- Reset mid-frame returns the FSM to `S_SYNC`. The rest of that frame is discarded, and capture resumes at address 0 on the next full frame.

## Timing
- Reset values:
  - `vram_wr_en_o`=0, `vram_wr_addr_o`=0, `vram_wr_data_o`=0, `frame_done_o`=0, `error_o`=0.
  - State is `S_SYNC`; all counters and the phase are 0.
- Latency: let k be the `clk_i` edge that first samples PCLK high for a phase-1 byte.
  - `vram_wr_en_o` is high for exactly one cycle after edge k+3.
  - Address and data are valid in that same cycle.
  - Outputs are registered.
- `vram_wr_addr_o` holds the address of the last write until the next write.
- `frame_done_o` is high for one cycle after the edge following VSYNC rise detection.
- Simultaneous HREF fall and phase-1 `pclk_rise`: the write occurs first, then the line-end clear.

## Configuration
Macro `CAPTURE_ERROR_CHECK_EN`.
- Defined: `error_o` sets, and stays set until reset, on any of these:
  - A line ends with the column counter not equal to ACTIVE_COLUMNS.
  - A line ends with phase 1, i.e. an odd byte count. The dangling byte is discarded.
  - A frame ends with the row counter not equal to ACTIVE_ROWS.
  - A write is suppressed by overflow.
- Not defined:
  - `error_o` is tied to 0 and the checking logic is absent.
  - The discard and suppression behaviour is unchanged.

## Test plan
Benches use ACTIVE_COLUMNS=4, ACTIVE_ROWS=2, `clk_i` period 10 ns and PCLK period 40 ns unless noted. Error cases run with `CAPTURE_ERROR_CHECK_EN` defined.
- Reset: hold `reset_i` high 3 cycles with random camera toggling -> all outputs 0, no write strobe.
- Pixel assembly: VSYNC high then low, then HREF with bytes 0x0A, 0xBC -> one write, addr 0, data 0xABC, strobe width 1 cycle.
- Full frame: 2 lines of 8 bytes, then VSYNC rises -> writes to addr 0..7 in order, one `frame_done_o` pulse, `error_o`=0. A second identical frame restarts at addr 0.
- Short line: a line of 6 bytes, then HREF falls -> 3 writes, `error_o`=1 and stays 1 after the next good frame.
- Odd byte: a line of 7 bytes -> 3 writes, last byte discarded, `error_o`=1. Undefining the macro -> same writes, `error_o` stays 0.
- Mid-frame start and reset:
  - Assert `reset_i` after 3 writes -> no further writes until a VSYNC high-low sequence, then the next frame writes from addr 0.
  - Bytes before the first VSYNC -> no writes.
